// File: rtl/inst_fetch_queue.sv
// Instruction fetcher: direct-mapped I-cache with multi-word lines, line-refill FSM
// towards the memory controller, and a FIFO fetch queue drained by the dispatcher.
module inst_fetch_queue #(
    parameter int          SETS       = 64,
    parameter int          LINE_WORDS = 4,
    parameter int          QDEPTH     = 8,
    parameter logic [31:0] RESET_PC   = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        inst_MC_flag,
    input  logic [31:0] inst_MC,
    output logic        inst_MC_req,
    output logic [31:0] inst_MC_addr,
    input  logic        ID_stall,
    output logic        inst_ID_flag,
    output logic [31:0] inst_ID,
    output logic [31:0] inst_ID_pc,
    input  logic        jump_flag,
    input  logic [31:0] jump_pc,
    output logic [31:0] now_pc
);
    localparam int WB = $clog2(LINE_WORDS);
    localparam int IB = $clog2(SETS);
    localparam int AW = IB + WB;
    localparam int TW = 30 - AW;
    localparam int CW = (WB > 0) ? WB : 1;
    localparam int QW = $clog2(QDEPTH);
    localparam logic [QW:0]   Q_FULL    = (QW + 1)'(QDEPTH);
    localparam logic [CW-1:0] LAST_WORD = CW'(LINE_WORDS - 1);

    typedef enum logic [1:0] {IDLE, REFILL, DROP} state_t;
    state_t state, state_next;

    logic [31:0]   pc;
    logic [SETS-1:0] valid;
    logic [TW-1:0] tag_mem   [SETS];
    logic [31:0]   line_data [SETS*LINE_WORDS];
    logic [31:0]   q_inst    [QDEPTH];
    logic [31:0]   q_pc      [QDEPTH];
    logic [QW-1:0] head, tail;
    logic [QW:0]   count;
    logic [31:0]   base;
    logic [CW-1:0] cnt;

    logic [IB-1:0] pc_index, base_index;
    logic [TW-1:0] pc_tag, base_tag;
    logic [AW-1:0] pc_daddr, fill_daddr;
    logic hit, full, empty, pop, push, miss_start, mc_word, last_word, wr_word, line_done;

    assign pc_index   = pc[2+WB +: IB];
    assign pc_tag     = pc[2+AW +: TW];
    assign pc_daddr   = pc[2 +: AW];
    assign base_index = base[2+WB +: IB];
    assign base_tag   = base[2+AW +: TW];
    assign fill_daddr = base[2 +: AW] + AW'(cnt);

    assign hit   = valid[pc_index] && (tag_mem[pc_index] == pc_tag);
    assign full  = (count == Q_FULL);
    assign empty = (count == '0);
    assign pop   = rdy && !empty && !ID_stall && !jump_flag;
    assign push  = rdy && hit && (state == IDLE) && (!full || pop) && !jump_flag;
    assign miss_start = rdy && (state == IDLE) && !hit && !full && !jump_flag;
    // MC words are only meaningful while a refill (live or abandoned) is outstanding
    assign mc_word   = rdy && inst_MC_flag && (state != IDLE);
    assign last_word = mc_word && (cnt == LAST_WORD);
    assign wr_word   = mc_word && (state == REFILL) && !jump_flag;
    assign line_done = last_word && (state == REFILL) && !jump_flag;

    assign inst_ID_flag = pop;
    assign inst_ID      = empty ? 32'h0 : q_inst[head];
    assign inst_ID_pc   = empty ? 32'h0 : q_pc[head];
    assign now_pc       = pc;

    // Refill FSM next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (miss_start) state_next = REFILL;
                else            state_next = IDLE;
            end
            REFILL: begin
                if (last_word)              state_next = IDLE;
                else if (rdy && jump_flag)  state_next = DROP;
                else                        state_next = REFILL;
            end
            DROP: begin
                if (last_word) state_next = IDLE;
                else           state_next = DROP;
            end
            default: state_next = IDLE;
        endcase
    end

    // Refill FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst)      state <= IDLE;
        else if (rdy) state <= state_next;
    end

    // PC, queue pointers, valid bits and MC request sequencing
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc           <= RESET_PC;
            valid        <= '0;
            head         <= '0;
            tail         <= '0;
            count        <= '0;
            base         <= 32'h0;
            cnt          <= '0;
            inst_MC_req  <= 1'b0;
            inst_MC_addr <= 32'h0;
        end else if (rdy) begin
            if (jump_flag)  pc <= jump_pc;
            else if (push)  pc <= pc + 32'd4;

            if (jump_flag) begin
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                if (push) tail <= tail + 1'b1;
                if (pop)  head <= head + 1'b1;
                if (push && !pop)      count <= count + 1'b1;
                else if (pop && !push) count <= count - 1'b1;
            end

            // Clearing valid at refill entry keeps a partially filled line from hitting
            if (miss_start) begin
                base            <= {pc[31:2+WB], {(2+WB){1'b0}}};
                cnt             <= '0;
                inst_MC_req     <= 1'b1;
                inst_MC_addr    <= {pc[31:2+WB], {(2+WB){1'b0}}};
                valid[pc_index] <= 1'b0;
            end else if (mc_word) begin
                if (last_word) begin
                    cnt         <= '0;
                    inst_MC_req <= 1'b0;
                end else begin
                    cnt          <= cnt + 1'b1;
                    inst_MC_addr <= inst_MC_addr + 32'd4;
                end
            end

            if (line_done) valid[base_index] <= 1'b1;
        end
    end

    // Cache and queue storage (contents are qualified by valid bits and count)
    always_ff @(posedge clk) begin
        if (rdy) begin
            if (push) begin
                q_inst[tail] <= line_data[pc_daddr];
                q_pc[tail]   <= pc;
            end
            if (wr_word)   line_data[fill_daddr] <= inst_MC;
            if (line_done) tag_mem[base_index]   <= base_tag;
        end
    end
endmodule
